// File: rtl/gmp_round_ctrl_if.sv
// Signal bundle between the round sequencer and its surroundings.
//   start, submit     : player controls (board -> sequencer)
//   switch            : player answer, binary
//   lfsr_val, lfsr_en : operand source and its step pulse
//   led               : operand currently displayed
//   phase             : 0 IDLE, 1 SHOW, 2 INPUT, 3 CHECK, 4 RESULT
//   expected          : running operand sum mod 100
//   result_valid/_correct : verdict of the last round
//   score_tens/_units : saturating BCD score
// master = board/LFSR side, slave = the sequencer.
interface gmp_round_ctrl_if;
  logic       start;
  logic       submit;
  logic [6:0] switch;
  logic [6:0] lfsr_val;
  logic       lfsr_en;
  logic [6:0] led;
  logic [2:0] phase;
  logic [6:0] expected;
  logic       result_valid;
  logic       result_correct;
  logic [3:0] score_tens;
  logic [3:0] score_units;

  modport master (
    output start, submit, switch, lfsr_val,
    input  lfsr_en, led, phase, expected, result_valid, result_correct,
           score_tens, score_units
  );

  modport slave (
    input  start, submit, switch, lfsr_val,
    output lfsr_en, led, phase, expected, result_valid, result_correct,
           score_tens, score_units
  );
endinterface

// File: rtl/gmp_round_ctrl.sv
// Round sequencer for the mental-math game.
// Steps an external LFSR NUM_TERMS times, holding each operand on led for
// SHOW_CYCLES, accumulates the sum mod 100, opens an INPUT_CYCLES answer
// window, judges the player's switch value and keeps a saturating BCD score.
// Ports:
//   clk   : system clock, rising edge
//   rst   : asynchronous reset, active low
//   bus   : gmp_round_ctrl_if.slave (see interface file for signal list)
// All outputs are registered.
module gmp_round_ctrl #(
  parameter int NUM_TERMS     = 4,
  parameter int SHOW_CYCLES   = 4,
  parameter int INPUT_CYCLES  = 6,
  parameter int RESULT_CYCLES = 4
) (
  input logic            clk,
  input logic            rst,
  gmp_round_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SHOW   = 3'd1,
    INPUT  = 3'd2,
    CHECK  = 3'd3,
    RESULT = 3'd4
  } state_e;

  localparam logic [3:0] TERM_LAST   = 4'(NUM_TERMS - 1);
  localparam logic [7:0] SHOW_LAST   = 8'(SHOW_CYCLES - 1);
  localparam logic [7:0] INPUT_LAST  = 8'(INPUT_CYCLES - 1);
  localparam logic [7:0] RESULT_LAST = 8'(RESULT_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] k_q;                 // term index
  logic [7:0] d_q;                 // dwell counter within a term
  logic [7:0] w_q;                 // answer window counter
  logic [7:0] r_q;                 // verdict hold counter
  logic [6:0] expected_q;
  logic [6:0] led_q;
  logic [6:0] answer_q;            // switch value captured on submit
  logic       timeout_q;
  logic       lfsr_en_q;
  logic       result_valid_q;
  logic       result_correct_q;
  logic [3:0] tens_q;
  logic [3:0] units_q;

  logic       round_start;
  logic       show_tick;
  logic       show_last;
  logic       lfsr_en_d;
  logic       correct;
  logic       score_max;
  logic [7:0] sum_raw;
  logic [7:0] sum_once;
  logic [6:0] sum_mod;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: state_d gets a default before the case so no path can infer a latch.
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = SHOW;
      SHOW:    if (d_q == SHOW_LAST && k_q == TERM_LAST) state_d = INPUT;
      INPUT:   if (bus.submit || w_q == INPUT_LAST) state_d = CHECK;
      CHECK:   state_d = RESULT;
      RESULT:  if (r_q == RESULT_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath decode.
  always_comb begin
    round_start = (state_q == IDLE) && bus.start;
    show_tick   = (state_q == SHOW) && (d_q == 8'd0);
    show_last   = (state_q == SHOW) && (d_q == SHOW_LAST);
    // lfsr_en is registered, so raise it one cycle ahead of every d==0 cycle:
    // on the start cycle and at the end of each term that is not the last.
    lfsr_en_d   = round_start || (show_last && (k_q != TERM_LAST));
    // A 7-bit answer of 100..127 never equals expected (always < 100).
    correct     = !timeout_q && (answer_q == expected_q);
    score_max   = (tens_q == 4'd9) && (units_q == 4'd9);
    // Sum is at most 99 + 127 = 226, so two conditional subtractions suffice.
    sum_raw     = {1'b0, expected_q} + {1'b0, bus.lfsr_val};
    sum_once    = (sum_raw >= 8'd100) ? sum_raw - 8'd100 : sum_raw;
    sum_mod     = (sum_once >= 8'd100) ? 7'(sum_once - 8'd100) : sum_once[6:0];
  end

  // Counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_q              <= '0;
      d_q              <= '0;
      w_q              <= '0;
      r_q              <= '0;
      expected_q       <= '0;
      led_q            <= '0;
      answer_q         <= '0;
      timeout_q        <= 1'b0;
      lfsr_en_q        <= 1'b0;
      result_valid_q   <= 1'b0;
      result_correct_q <= 1'b0;
      tens_q           <= '0;
      units_q          <= '0;
    end else begin
      lfsr_en_q      <= lfsr_en_d;
      result_valid_q <= (state_d == RESULT);

      case (state_q)
        IDLE: begin
          if (round_start) begin
            expected_q <= '0;
            k_q        <= '0;
            d_q        <= '0;
            led_q      <= '0;
          end
        end

        SHOW: begin
          // lfsr_val is the pre-step value here; the LFSR steps on this edge.
          if (show_tick) begin
            led_q      <= bus.lfsr_val;
            expected_q <= sum_mod;
          end
          if (show_last) begin
            d_q <= '0;
            if (k_q == TERM_LAST) begin
              led_q <= '0;
              w_q   <= '0;
            end else begin
              k_q <= k_q + 4'd1;
            end
          end else begin
            d_q <= d_q + 8'd1;
          end
        end

        INPUT: begin
          // submit on the final window cycle still counts as an answer.
          if (bus.submit) begin
            answer_q  <= bus.switch;
            timeout_q <= 1'b0;
          end else if (w_q == INPUT_LAST) begin
            timeout_q <= 1'b1;
          end else begin
            w_q <= w_q + 8'd1;
          end
        end

        CHECK: begin
          result_correct_q <= correct;
          r_q              <= '0;
          if (correct && !score_max) begin
            if (units_q == 4'd9) begin
              units_q <= '0;
              tens_q  <= tens_q + 4'd1;
            end else begin
              units_q <= units_q + 4'd1;
            end
          end
        end

        RESULT: begin
          if (r_q == RESULT_LAST) result_correct_q <= 1'b0;
          else                    r_q <= r_q + 8'd1;
        end

        default: ;
      endcase
    end
  end

  assign bus.phase          = state_q;
  assign bus.lfsr_en        = lfsr_en_q;
  assign bus.led            = led_q;
  assign bus.expected       = expected_q;
  assign bus.result_valid   = result_valid_q;
  assign bus.result_correct = result_correct_q;
  assign bus.score_tens     = tens_q;
  assign bus.score_units    = units_q;

endmodule

// File: tb/tb_gmp_round_ctrl.sv
// Self-checking bench for gmp_round_ctrl.
// A small LFSR model feeds a per-round operand table; verdicts, displayed
// operands and running sums are queued when a round is launched and compared
// when the DUT presents them. Outputs are sampled on the falling edge.
module tb_gmp_round_ctrl;

  localparam int NT = 4;
  localparam int SC = 4;
  localparam int IC = 6;
  localparam int RC = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  gmp_round_ctrl_if bus();

  gmp_round_ctrl #(
    .NUM_TERMS    (NT),
    .SHOW_CYCLES  (SC),
    .INPUT_CYCLES (IC),
    .RESULT_CYCLES(RC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic correct;
    int   sum;
    int   tens;
    int   units;
  } verdict_t;

  verdict_t sb_q[$];
  int       led_q[$];
  int       sum_q[$];

  int n_vec = 0;
  int n_err = 0;

  int         cyc = 0;
  logic [6:0] ops [4];
  int         lfsr_idx = 0;
  int         model_score = 0;
  int         pulse_total = 0;
  int         last_pulse = 0;
  bit         first_pulse = 1'b1;
  logic       prev_en = 1'b0;
  logic       prev_rv = 1'b0;
  verdict_t   mon_v;
  int         mon_e;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // LFSR model: steps to the next table entry after an lfsr_en cycle.
  initial begin
    logic step;
    forever begin
      @(negedge clk);
      step = bus.lfsr_en;
      @(posedge clk);
      #1;
      if (step === 1'b1) lfsr_idx++;
      bus.lfsr_val = ops[lfsr_idx & 3];
    end
  end

  // Monitor: operand/sum after each step, pulse spacing, verdict on result_valid rise.
  always @(negedge clk) begin
    if (!rst) begin
      prev_en     = 1'b0;
      prev_rv     = 1'b0;
      first_pulse = 1'b1;
    end else begin
      if (prev_en) begin
        check("led_avail", int'(led_q.size() > 0), 1);
        if (led_q.size() > 0) begin
          mon_e = led_q.pop_front();
          check("led", int'(bus.led), mon_e);
          mon_e = sum_q.pop_front();
          check("expected_run", int'(bus.expected), mon_e);
        end
      end
      if (bus.phase == 3'd0) first_pulse = 1'b1;
      if (bus.lfsr_en) begin
        if (!first_pulse) check("pulse_gap", cyc - last_pulse, SC);
        first_pulse = 1'b0;
        last_pulse  = cyc;
        pulse_total++;
      end
      if (bus.result_valid && !prev_rv) begin
        check("verdict_avail", int'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
          mon_v = sb_q.pop_front();
          check("result_correct", int'(bus.result_correct), int'(mon_v.correct));
          check("expected_final", int'(bus.expected), mon_v.sum);
          check("score_tens", int'(bus.score_tens), mon_v.tens);
          check("score_units", int'(bus.score_units), mon_v.units);
        end
      end
      prev_en = bus.lfsr_en;
      prev_rv = bus.result_valid;
    end
  end

  // One full round. sub_at = INPUT cycle (1-based) carrying submit, 0 = none.
  // noise drives start in SHOW/INPUT/RESULT and submit throughout SHOW.
  task automatic run_round(input logic [6:0] o0, input logic [6:0] o1,
                           input logic [6:0] o2, input logic [6:0] o3,
                           input int sub_at, input logic [6:0] sw, input bit noise);
    int       sum = 0;
    int       used;
    int       nonidle = 0;
    int       n_show = 0, n_in = 0, n_chk = 0, n_res = 0, n_rv = 0;
    int       base;
    int       last_p = 1;
    int       guard = 0;
    bit       order_ok = 1'b1;
    verdict_t v;
    logic [2:0] p;

    ops[0] = o0; ops[1] = o1; ops[2] = o2; ops[3] = o3;
    for (int i = 0; i < NT; i++) begin
      sum = (sum + int'(ops[i])) % 100;
      led_q.push_back(int'(ops[i]));
      sum_q.push_back(sum);
    end
    v.correct = (sub_at > 0) && (int'(sw) == sum);
    if (v.correct && model_score < 99) model_score++;
    v.sum   = sum;
    v.tens  = model_score / 10;
    v.units = model_score % 10;
    sb_q.push_back(v);
    used = (sub_at > 0) ? sub_at : IC;

    @(negedge clk);
    lfsr_idx     = 0;
    bus.lfsr_val = ops[0];
    bus.switch   = sw;
    bus.start    = 1'b1;
    base         = pulse_total;
    @(negedge clk);
    bus.start = 1'b0;
    while (bus.phase != 3'd0 && guard < 300) begin
      p = bus.phase;
      guard++;
      nonidle++;
      if (int'(p) < last_p) order_ok = 1'b0;
      last_p = int'(p);
      case (p)
        3'd1:    n_show++;
        3'd2:    n_in++;
        3'd3:    n_chk++;
        3'd4:    n_res++;
        default: order_ok = 1'b0;
      endcase
      if (bus.result_valid) n_rv++;
      if (p == 3'd2 && n_in == 1) check("led_input", int'(bus.led), 0);
      bus.start  = noise && (p == 3'd1 || p == 3'd2 || p == 3'd4);
      bus.submit = (noise && p == 3'd1) || (p == 3'd2 && n_in == sub_at);
      @(negedge clk);
    end
    bus.start  = 1'b0;
    bus.submit = 1'b0;

    check("round_done", int'(guard < 300), 1);
    check("show_cycles", n_show, NT * SC);
    check("input_cycles", n_in, used);
    check("check_cycles", n_chk, 1);
    check("result_cycles", n_res, RC);
    check("result_valid_cycles", n_rv, RC);
    check("phase_order", int'(order_ok), 1);
    check("round_len", 1 + nonidle, 1 + NT * SC + used + 1 + RC);
    check("lfsr_pulses", pulse_total - base, NT);
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.submit   = 1'b0;
    bus.switch   = '0;
    bus.lfsr_val = '0;
    ops[0] = '0; ops[1] = '0; ops[2] = '0; ops[3] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_phase", int'(bus.phase), 0);
    check("rst_led", int'(bus.led), 0);
    check("rst_expected", int'(bus.expected), 0);
    check("rst_lfsr_en", int'(bus.lfsr_en), 0);
    check("rst_result_valid", int'(bus.result_valid), 0);
    check("rst_tens", int'(bus.score_tens), 0);
    check("rst_units", int'(bus.score_units), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 1: basic correct round, submit on 2nd input cycle
    run_round(7'd10, 7'd20, 7'd30, 7'd45, 2, 7'd5, 1'b0);
    // 2: wrong answer, then timeout with the right value held
    run_round(7'd10, 7'd20, 7'd30, 7'd45, 1, 7'd6, 1'b0);
    run_round(7'd10, 7'd20, 7'd30, 7'd45, 0, 7'd5, 1'b0);
    // 2b: submit on the last window cycle still wins over timeout
    run_round(7'd10, 7'd20, 7'd30, 7'd45, IC, 7'd5, 1'b0);
    // 3: maximal operands, double reduction; 108 aliases 8 only mod 100
    run_round(7'd127, 7'd127, 7'd127, 7'd127, 3, 7'd8, 1'b0);
    run_round(7'd127, 7'd127, 7'd127, 7'd127, 3, 7'd108, 1'b0);
    // 5: stray start/submit ignored
    run_round(7'd10, 7'd20, 7'd30, 7'd45, 3, 7'd5, 1'b1);
    run_round(7'd99, 7'd1, 7'd50, 7'd60, 4, 7'd10, 1'b1);
    // 4: climb to 98, then two more correct rounds saturate at 99
    while (model_score < 98) run_round(7'd10, 7'd20, 7'd30, 7'd45, 1, 7'd5, 1'b0);
    run_round(7'd10, 7'd20, 7'd30, 7'd45, 1, 7'd5, 1'b0);
    run_round(7'd10, 7'd20, 7'd30, 7'd45, 1, 7'd5, 1'b0);
    check("sat_tens", int'(bus.score_tens), 9);
    check("sat_units", int'(bus.score_units), 9);

    // 6: asynchronous reset mid-SHOW
    ops[0] = 7'd30; ops[1] = 7'd40; ops[2] = 7'd50; ops[3] = 7'd60;
    led_q.push_back(30); sum_q.push_back(30);
    led_q.push_back(40); sum_q.push_back(70);
    @(negedge clk);
    lfsr_idx     = 0;
    bus.lfsr_val = ops[0];
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_reset_phase", int'(bus.phase), 1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_phase", int'(bus.phase), 0);
    check("arst_led", int'(bus.led), 0);
    check("arst_expected", int'(bus.expected), 0);
    check("arst_lfsr_en", int'(bus.lfsr_en), 0);
    check("arst_result_valid", int'(bus.result_valid), 0);
    check("arst_tens", int'(bus.score_tens), 0);
    check("arst_units", int'(bus.score_units), 0);
    model_score = 0;
    led_q.delete();
    sum_q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_reset_expected", int'(bus.expected), 0);
    run_round(7'd7, 7'd8, 7'd9, 7'd10, 1, 7'd34, 1'b0);

    check("sb_drained", sb_q.size(), 0);
    check("led_drained", led_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gmp_round_ctrl.md
Name: gmp_round_ctrl

Overview:
- Round sequencer for the CPLD mental-math game.
- Drives an external LFSR to produce NUM_TERMS operands and presents each one on the LEDs for a fixed dwell time.
- Accumulates the expected answer mod 100, then opens a timed input window and checks the player's switch value.
- Keeps a saturating BCD score for the 7-segment driver. Sits between the LFSR and the switch, LED and BCD I/O.

Parameters:
- NUM_TERMS, 4, operands shown per round (1..15).
- SHOW_CYCLES, 4, clock cycles each operand is held on led (2..255).
- INPUT_CYCLES, 6, length of the answer window in cycles (1..255).
- RESULT_CYCLES, 4, cycles the verdict is held before returning to IDLE (1..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin a round; sampled only in IDLE.
- submit  in  1  one-cycle answer strobe; sampled only in INPUT.
- switch  in  7  player answer, binary.
- lfsr_val  in  7  current LFSR output.
- lfsr_en  out  1  one-cycle pulse that steps the LFSR.
- led  out  7  operand currently shown; 0 outside SHOW.
- phase  out  3  encoding: 0 IDLE, 1 SHOW, 2 INPUT, 3 CHECK, 4 RESULT.
- expected  out  7  running sum mod 100.
- result_valid  out  1  high throughout RESULT.
- result_correct  out  1  verdict; meaningful only while result_valid is high.
- score_tens  out  4  BCD tens digit of the score.
- score_units  out  4  BCD units digit of the score.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - All outputs 0, including the score. expected=0, lfsr_en=0, led=0.
  - Term, dwell and window counters cleared.
  - Reset asserted mid-round aborts the round with no score change.
- IDLE:
  - On start=1, go to SHOW next cycle.
  - Clear expected and the term counter k; set dwell counter d=0.
  - start asserted in any other state is ignored.
- SHOW:
  - Dwell counter d runs 0..SHOW_CYCLES-1 for each term.
  - In the cycle where d==0:
    - lfsr_en=1 for exactly that cycle.
    - lfsr_val is sampled that same cycle (the pre-step value).
    - led <= lfsr_val.
    - expected <= (expected + lfsr_val) mod 100.
  - The mod-100 reduction uses conditional subtraction of 100, at most twice, since the intermediate sum is at most 99+127=226. No divider.
  - When d==SHOW_CYCLES-1: if k==NUM_TERMS-1, go to INPUT; otherwise increment k and reset d to 0.
  - A round therefore spends exactly NUM_TERMS*SHOW_CYCLES cycles in SHOW.
- INPUT:
  - led=0. Window counter w runs 0..INPUT_CYCLES-1.
  - If submit=1 on any cycle, capture switch and go to CHECK. This includes the cycle with w==INPUT_CYCLES-1; submit wins over timeout.
  - If w reaches INPUT_CYCLES-1 with no submit, go to CHECK flagged as a timeout.
  - Only the first submit counts. submit in any other state is ignored.
- CHECK (1 cycle):
  - correct = !timeout && (captured switch == expected).
  - Switch values 100..127 can never match.
  - If correct and the score is below 99, increment the BCD score (units wrap 9→0 with carry into tens).
  - If the score is 99, it stays 99.
  - A wrong answer leaves the score unchanged.
  - Go to RESULT.
- RESULT:
  - result_valid=1 and result_correct is registered, for exactly RESULT_CYCLES cycles.
  - Then go to IDLE with result_valid=0.
  - expected holds its value until the next start.
  - start during RESULT is ignored.
- Timing:
  - phase and all other outputs are registered and change on clock edges only.
  - Total round length from the start cycle to return to IDLE: 1 + NUM_TERMS*SHOW_CYCLES + (input cycles used) + 1 + RESULT_CYCLES.
- Score:
  - Persists across rounds; cleared only by reset.
  - score_tens and score_units are always valid BCD (0..9).

Test Plan:
1. Defaults; lfsr_val model yields 10, 20, 30, 45; start pulse; submit=1 with switch=5 in the 2nd INPUT cycle → lfsr_en pulses exactly 4 times, 4 cycles apart. led shows 10, 20, 30, 45. expected=5. result_correct=1 for 4 cycles. Score becomes 0/1.
2. Same operands; switch=6 submitted → result_correct=0, score unchanged. Next, no submit at all → timeout after 6 INPUT cycles, result_correct=0 even with switch=5 held.
3. Operands 127, 127, 127, 127 → expected sequence 27, 54, 81, 8. switch=8 gives correct. switch=108 gives wrong.
4. Preload the score to 98 via 98 correct rounds, then 2 more correct rounds → score goes 99 then stays 99. Digits remain BCD throughout.
5. Assert submit during SHOW and start during SHOW, INPUT and RESULT → all ignored. Phase sequence is 1,1..,2,..,3,4 with exact cycle counts per the timing formula.
6. Drop rst asynchronously mid-SHOW (between clock edges) → all outputs 0 immediately, phase=0. After release, a fresh round starts cleanly with expected cleared.
